// File: rtl/bit_shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : bit_shift_sequencer_pkg
// Brief  : State encodings and shift-direction constants for the sequencer.
// Rev    : 1.0
// ============================================================================
package bit_shift_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    localparam logic LEFT_SHIFT  = 1'b0;
    localparam logic RIGHT_SHIFT = 1'b1;

endpackage : bit_shift_sequencer_pkg
`default_nettype wire

// File: rtl/bit_shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : bit_shift_sequencer_if
// Brief  : Command / result handshake bundle; cmd_rotate exists only when
//          BIT_SHIFT_SEQUENCER_ROTATE_EN is defined.
// Rev    : 1.0
// ============================================================================
interface bit_shift_sequencer_if #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [WORD_WIDTH*DEPTH-1:0] cmd_data;
    logic [WORD_WIDTH-1:0]       cmd_amount;
    logic                        cmd_direction;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
    logic                        cmd_rotate;
`endif
    logic                        result_valid;
    logic                        result_ready;
    logic [WORD_WIDTH*DEPTH-1:0] result_data;
    logic                        result_error;
    logic                        busy;

    modport master (
        output cmd_valid, cmd_data, cmd_amount, cmd_direction,
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
        output cmd_rotate,
`endif
        output result_ready,
        input  cmd_ready, result_valid, result_data, result_error, busy
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_amount, cmd_direction,
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
        input  cmd_rotate,
`endif
        input  result_ready,
        output cmd_ready, result_valid, result_data, result_error, busy
    );

endinterface : bit_shift_sequencer_if
`default_nettype wire

// File: rtl/bit_shift_sequencer_shifter.sv
`default_nettype none
// ============================================================================
// Module : Bit_Shifter
// Brief  : Combinational 3-word-window shifter; left word is most significant.
// Rev    : 1.0
// ============================================================================
module Bit_Shifter
    import bit_shift_sequencer_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int AMT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
    input  wire logic [WORD_WIDTH-1:0] left_i,
    input  wire logic [WORD_WIDTH-1:0] center_i,
    input  wire logic [WORD_WIDTH-1:0] right_i,
    input  wire logic [AMT_WIDTH-1:0]  amount_i,
    input  wire logic                  direction_i,
    output logic      [WORD_WIDTH-1:0] left_o,
    output logic      [WORD_WIDTH-1:0] center_o,
    output logic      [WORD_WIDTH-1:0] right_o
);

    logic [3*WORD_WIDTH-1:0] w_window;
    logic [3*WORD_WIDTH-1:0] w_shifted;

    always_comb begin
        w_window = {left_i, center_i, right_i};
        case (direction_i)
            LEFT_SHIFT:  w_shifted = w_window << amount_i;
            default:     w_shifted = w_window >> amount_i;
        endcase
    end

    assign left_o   = w_shifted[3*WORD_WIDTH-1:2*WORD_WIDTH];
    assign center_o = w_shifted[2*WORD_WIDTH-1:WORD_WIDTH];
    assign right_o  = w_shifted[WORD_WIDTH-1:0];

endmodule : Bit_Shifter
`default_nettype wire

// File: rtl/bit_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module : bit_shift_sequencer
// Brief  : Multi-word shift through one shared window shifter, one word per
//          cycle. BIT_SHIFT_SEQUENCER_ROTATE_EN adds circular rotation.
// Rev    : 1.0
// ============================================================================
module bit_shift_sequencer
    import bit_shift_sequencer_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input wire logic           clock,
    input wire logic           reset_n,
    bit_shift_sequencer_if.slave bus
);

    localparam int INDEX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int VEC_WIDTH    = WORD_WIDTH * DEPTH;
    localparam int SH_AMT_WIDTH = $clog2(WORD_WIDTH) + 1;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(DEPTH - 1);
    localparam logic [WORD_WIDTH-1:0]  MAX_AMOUNT = WORD_WIDTH'(WORD_WIDTH);

    state_t                   state_q,  state_d;
    logic [INDEX_WIDTH-1:0]   index_q,  index_d;
    logic [VEC_WIDTH-1:0]     src_q,    src_d;
    logic [VEC_WIDTH-1:0]     dst_q,    dst_d;
    logic [SH_AMT_WIDTH-1:0]  amount_q, amount_d;
    logic                     dir_q,    dir_d;
    logic                     error_q,  error_d;
    logic                     rotate_q;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
    logic                     rotate_d;
`endif

    logic                     w_accept;
    logic                     w_illegal;
    logic [WORD_WIDTH-1:0]    w_left;
    logic [WORD_WIDTH-1:0]    w_center;
    logic [WORD_WIDTH-1:0]    w_right;
    logic [WORD_WIDTH-1:0]    w_sh_center;

    assign w_accept  = bus.cmd_valid && (state_q == S_IDLE);
    assign w_illegal = bus.cmd_amount > MAX_AMOUNT;

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = w_illegal ? S_DONE : S_SHIFT;
            S_SHIFT: if (index_q == LAST_INDEX) state_d = S_DONE;
            S_DONE:  if (bus.result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        bus.cmd_ready    = (state_q == S_IDLE);
        bus.result_valid = (state_q == S_DONE);
        bus.busy         = (state_q != S_IDLE);
    end

    assign bus.result_data  = dst_q;
    assign bus.result_error = error_q;

    // Edge words see zeros, or the opposite end of the vector when rotating.
    always_comb begin
        w_center = src_q[int'(index_q)*WORD_WIDTH +: WORD_WIDTH];
        if (index_q == LAST_INDEX)
            w_left = rotate_q ? src_q[WORD_WIDTH-1:0] : '0;
        else
            w_left = src_q[(int'(index_q)+1)*WORD_WIDTH +: WORD_WIDTH];
        if (index_q == '0)
            w_right = rotate_q ? src_q[VEC_WIDTH-1 -: WORD_WIDTH] : '0;
        else
            w_right = src_q[(int'(index_q)-1)*WORD_WIDTH +: WORD_WIDTH];
    end

    Bit_Shifter #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_shifter (
        .left_i      (w_left),
        .center_i    (w_center),
        .right_i     (w_right),
        .amount_i    (amount_q),
        .direction_i (dir_q),
        .left_o      (),
        .center_o    (w_sh_center),
        .right_o     ()
    );

    // Captured amount keeps only the shifter-width bits; larger values never reach SHIFT.
    always_comb begin
        index_d  = index_q;
        src_d    = src_q;
        dst_d    = dst_q;
        amount_d = amount_q;
        dir_d    = dir_q;
        error_d  = error_q;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
        rotate_d = rotate_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    src_d    = bus.cmd_data;
                    amount_d = bus.cmd_amount[SH_AMT_WIDTH-1:0];
                    dir_d    = bus.cmd_direction;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
                    rotate_d = bus.cmd_rotate;
`endif
                    index_d  = '0;
                    error_d  = w_illegal;
                    if (w_illegal) dst_d = '0;
                end
            end
            S_SHIFT: begin
                dst_d[int'(index_q)*WORD_WIDTH +: WORD_WIDTH] = w_sh_center;
                if (index_q != LAST_INDEX) index_d = index_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            amount_q <= '0;
            dir_q    <= LEFT_SHIFT;
            error_q  <= 1'b0;
        end else begin
            index_q  <= index_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            amount_q <= amount_d;
            dir_q    <= dir_d;
            error_q  <= error_d;
        end
    end

`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rotate_q <= 1'b0;
        else          rotate_q <= rotate_d;
    end
`else
    assign rotate_q = 1'b0;
`endif

endmodule : bit_shift_sequencer
`default_nettype wire

// File: tb/tb_bit_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_bit_shift_sequencer
// Brief  : Directed and randomized checks against a whole-vector shift model.
// Rev    : 1.0
// ============================================================================
module tb_bit_shift_sequencer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = W * D;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
    localparam bit HAS_ROT = 1'b1;
`else
    localparam bit HAS_ROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bit_shift_sequencer_if #(.WORD_WIDTH(W), .DEPTH(D)) bus ();

    bit_shift_sequencer #(
        .WORD_WIDTH (W),
        .DEPTH      (D)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-vector reference: treat the DEPTH words as one N-bit number.
    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int amt,
                                           input bit dir, input bit rot);
        logic [N-1:0] r;
        if (amt > W)      r = '0;
        else if (!dir)    r = rot ? ((d << amt) | (d >> (N - amt))) : (d << amt);
        else              r = rot ? ((d >> amt) | (d << (N - amt))) : (d >> amt);
        return r;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_cmd(input logic [N-1:0] d, input int amt, input bit dir,
                           input bit rot, input int hold, input string tag);
        int           lat;
        logic [N-1:0] exp_data;
        bit           eff_rot;
        eff_rot  = rot & HAS_ROT;
        exp_data = model(d, amt, dir, eff_rot);
        check({tag, "/cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid     = 1'b1;
        bus.cmd_data      = d;
        bus.cmd_amount    = W'(amt);
        bus.cmd_direction = dir;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
        bus.cmd_rotate    = eff_rot;
`endif
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.result_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), (amt > W) ? 64'd1 : 64'(D + 1));
        check({tag, "/data"},  64'(bus.result_data),  64'(exp_data));
        check({tag, "/error"}, 64'(bus.result_error), 64'(amt > W));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, 64'(bus.result_valid), 64'd1);
            check({tag, "/hold_data"},  64'(bus.result_data),  64'(exp_data));
            check({tag, "/hold_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
        end
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check({tag, "/post_valid"},     64'(bus.result_valid), 64'd0);
        check({tag, "/post_cmd_ready"}, 64'(bus.cmd_ready),    64'd1);
        check({tag, "/post_busy"},      64'(bus.busy),         64'd0);
    endtask

    initial begin
        int vcount;
        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_data      = '0;
        bus.cmd_amount    = '0;
        bus.cmd_direction = 1'b0;
`ifdef BIT_SHIFT_SEQUENCER_ROTATE_EN
        bus.cmd_rotate    = 1'b0;
`endif
        bus.result_ready  = 1'b0;

        #12;
        check("reset/cmd_ready",    64'(bus.cmd_ready),    64'd1);
        check("reset/result_valid", 64'(bus.result_valid), 64'd0);
        check("reset/result_data",  64'(bus.result_data),  64'd0);
        check("reset/result_error", 64'(bus.result_error), 64'd0);
        check("reset/busy",         64'(bus.busy),         64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(32'h01234567, 4, 1'b0, 1'b0, 0, "left4");
        run_cmd(32'h89ABCDEF, 8, 1'b1, 1'b0, 0, "right8");
        run_cmd(32'h89ABCDEF, 0, 1'b1, 1'b0, 0, "amt0");
        run_cmd(32'h89ABCDEF, 9, 1'b0, 1'b0, 0, "illegal9");
        run_cmd(32'h0F0F0F0F, 8, 1'b0, 1'b0, 0, "clear_err");
        run_cmd(32'hDEADBEEF, 3, 1'b1, 1'b0, 6, "backpressure");
        run_cmd(32'h89ABCDEF, 4, 1'b0, 1'b1, 0, "rot_left4");
        run_cmd(32'h89ABCDEF, 8, 1'b1, 1'b1, 0, "rot_right8");

        // Reset during the second SHIFT cycle must discard the operation.
        bus.cmd_valid     = 1'b1;
        bus.cmd_data      = 32'hCAFEF00D;
        bus.cmd_amount    = 8'd5;
        bus.cmd_direction = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst/cmd_ready",    64'(bus.cmd_ready),    64'd1);
        check("midrst/result_valid", 64'(bus.result_valid), 64'd0);
        check("midrst/result_data",  64'(bus.result_data),  64'd0);
        check("midrst/result_error", 64'(bus.result_error), 64'd0);
        check("midrst/busy",         64'(bus.busy),         64'd0);
        @(negedge clk); rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.result_valid === 1'b1) vcount++;
        end
        check("midrst/no_result", 64'(vcount), 64'd0);

        for (int t = 0; t < 40; t++) begin
            int amt;
            amt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 255))
                                               : int'($urandom_range(0, W));
            run_cmd($urandom, amt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bit_shift_sequencer
`default_nettype wire

// File: doc/bit_shift_sequencer.md
# bit_shift_sequencer

Sequences a multi-word logical (optionally rotating) shift of a DEPTH-word vector through one shared 3-word-window bit shifter, processing one word per cycle. It sits between a command producer and a result consumer, both using valid/ready handshakes. It owns the source and destination buffers, generates the neighbour-word window for each word, and drives the shifter's amount and direction for the whole operation.

## Interface
- WORD_WIDTH, 8, bits per word; also the width of the shifter datapath.
- DEPTH, 4, words per vector; must be ≥ 2. Word 0 is least significant.
- INDEX_WIDTH, clog2(DEPTH), width of the internal word index.
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_data  in  WORD_WIDTH*DEPTH  vector to shift.
- cmd_amount  in  WORD_WIDTH  shift distance in bits; legal range 0..WORD_WIDTH.
- cmd_direction  in  1  0 = left (toward MSB), 1 = right.
- result_valid  out  1  result held in DONE.
- result_ready  in  1  consumer accepts.
- result_data  out  WORD_WIDTH*DEPTH  shifted vector; meaningful only while result_valid = 1.
- result_error  out  1  cmd_amount was greater than WORD_WIDTH; qualified by result_valid.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, capture cmd_data into src_buf, and cmd_amount and cmd_direction into registers; clear index to 0.
  - If cmd_amount > WORD_WIDTH, clear dst_buf, set result_error and go to DONE. Otherwise clear result_error and go to SHIFT.
- SHIFT, each cycle, for word i = index:
  - Shifter inputs: center = src_buf[i]; left = src_buf[i+1], or 0 when i = DEPTH-1; right = src_buf[i-1], or 0 when i = 0.
  - Shift amount is the captured cmd_amount zero-extended to the shifter's amount width; direction is the captured cmd_direction.
  - dst_buf[i] ← shifter centre output; index increments.
  - When i = DEPTH-1, go to DONE. Index does not wrap within one operation.
- DONE:
  - result_valid = 1; result_data = dst_buf. Both are held stable until result_ready.
  - On result_ready, go to IDLE next cycle.
  - cmd_ready stays 0, so a new command is never accepted in the same cycle a result is consumed.
- Zero fill: bits shifted past either end of the vector are lost; vacated bits are 0.
- Amount 0: dst_buf equals src_buf. Amount WORD_WIDTH: exact whole-word move.
- src_buf is never written during SHIFT, so in-place hazards are impossible.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - state = IDLE, index = 0;
  - src_buf = dst_buf = 0, result_error = 0;
  - outputs: cmd_ready = 1, result_valid = 0, result_data = 0, busy = 0.
- Reset mid-SHIFT or in DONE aborts the operation; the pending result is discarded and never presented.
- Latency for a legal amount: accept in cycle 0; SHIFT occupies cycles 1..DEPTH; result_valid rises in cycle DEPTH+1.
- Latency for an illegal amount (error): result_valid rises in cycle 1.
- Throughput with result_ready held high: one command every DEPTH+2 cycles (IDLE, DEPTH × SHIFT, DONE).
- cmd_ready, result_valid and busy are decoded directly from registered state, with no combinational input-to-output path.

## Configuration
- BIT_SHIFT_SEQUENCER_ROTATE_EN defined:
  - Adds input port cmd_rotate (1 bit), captured at accept.
  - When the captured cmd_rotate = 1, the edge neighbours wrap: left of word DEPTH-1 is src_buf[0], and right of word 0 is src_buf[DEPTH-1]. The result is a circular rotation of the full vector.
  - When cmd_rotate = 0, behaviour is zero fill.
- BIT_SHIFT_SEQUENCER_ROTATE_EN undefined: cmd_rotate is absent and only zero-fill logical shifts exist.

## Structure
- Package bit_shift_sequencer_pkg holds:
  - state encodings S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
  - direction constants LEFT_SHIFT = 1'b0, RIGHT_SHIFT = 1'b1.
- One sub-module: a single instance of the team's existing Bit_Shifter (WORD_WIDTH passed through). Only its centre output is used; the left and right outputs are left unconnected.
- Window multiplexing, buffers, index and FSM live in this module.

## Test plan
All scenarios use WORD_WIDTH = 8, DEPTH = 4.
- Left shift: cmd_data 0x01234567, amount 4, direction 0 → result_data 0x12345670, result_error 0, result_valid at cycle 5.
- Right shift by a whole word: cmd_data 0x89ABCDEF, amount 8, direction 1 → 0x0089ABCD. Same data, amount 0 → 0x89ABCDEF.
- Illegal amount: amount 9 → result_valid at cycle 1, result_error 1, result_data 0x00000000; the next legal command clears result_error.
- Backpressure: result_ready held low 6 cycles in DONE → result_data and result_valid stable, cmd_ready 0 throughout; ready high → IDLE one cycle later, then cmd_ready 1.
- Reset mid-operation: reset_n low during the second SHIFT cycle → all outputs at reset values immediately; no result_valid ever follows for that command.
- With BIT_SHIFT_SEQUENCER_ROTATE_EN: cmd_data 0x89ABCDEF, amount 4, left, cmd_rotate 1 → 0x9ABCDEF8. Right rotate by 8 → 0xEF89ABCD.
